wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the pipeline (P) writes immediately, multi-cycle
// results queue in a 2-entry FIFO, and a starve counter forces the FIFO head through.
module wb_arbiter #(
  parameter int unsigned D_WIDTH    = 32,
  parameter int unsigned A_WIDTH    = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    p_valid,
  input  logic [A_WIDTH-1:0]      p_addr,
  input  logic [D_WIDTH-1:0]      p_data,
  input  logic                    m_valid,
  input  logic [A_WIDTH-1:0]      m_addr,
  input  logic [D_WIDTH-1:0]      m_data,
  output logic                    m_ready,
  output logic                    wen,
  output logic [A_WIDTH-1:0]      waddr,
  output logic [D_WIDTH-1:0]      wdata,
  output logic                    stall_req,
  output logic [(2**A_WIDTH)-1:0] pend_mask,
  output logic                    err
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [A_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0] data;
  } entry_t;

  entry_t         ent_q [2];
  entry_t         ent_d [2];
  logic [1:0]     vld_q, vld_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           stall_q, stall_d;
  logic           err_q, err_d;

  logic           full, empty, push, fifo_gnt, p_gnt;
  entry_t         head;

  assign full     = &vld_q;
  assign empty    = ~|vld_q;
  assign head     = ent_q[rd_ptr_q];
  // While stalled the head wins; otherwise P has priority over the FIFO.
  assign fifo_gnt = !empty && (stall_q || !p_valid);
  assign p_gnt    = p_valid && !fifo_gnt;
  assign push     = m_valid && m_ready;

  assign stall_req = stall_q;
  assign err       = err_q;

  // Write port, handshake and pending mask; all forced quiet while in reset.
  always_comb begin
    m_ready   = rst_n && !full;
    wen       = 1'b0;
    waddr     = '0;
    wdata     = '0;
    pend_mask = '0;
    if (fifo_gnt) begin
      wen   = rst_n && (head.addr != '0);
      waddr = head.addr;
      wdata = head.data;
    end else if (p_gnt) begin
      wen   = rst_n && (p_addr != '0);
      waddr = p_addr;
      wdata = p_data;
    end
    for (int i = 0; i < 2; i++) begin
      if (vld_q[i]) pend_mask[ent_q[i].addr] = 1'b1;
    end
    pend_mask[0] = 1'b0;
    if (!rst_n) pend_mask = '0;
  end

  // FIFO, starve counter and status next-state.
  always_comb begin
    ent_d    = ent_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ fifo_gnt;
    cnt_d    = cnt_q;
    if (fifo_gnt) vld_d[rd_ptr_q] = 1'b0;
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      ent_d[wr_ptr_q] = '{addr: m_addr, data: m_data};
    end
    if (fifo_gnt || empty) begin
      cnt_d = '0;
    end else if (p_gnt && (cnt_q != CW'(STARVE_MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end
    stall_d = fifo_gnt ? 1'b0 : (stall_q || (cnt_d == CW'(STARVE_MAX)));
    err_d   = err_q || (stall_q && p_valid && !empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued as stimulus is driven and
// popped whenever the DUT asserts wen.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_valid, m_valid;
  logic [4:0]  p_addr, m_addr;
  logic [31:0] p_data, m_data;
  logic        m_ready, wen, stall_req, err;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pend_mask;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] sb [$];

  wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data),
    .m_ready(m_ready), .wen(wen), .waddr(waddr), .wdata(wdata),
    .stall_req(stall_req), .pend_mask(pend_mask), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    sb.push_back({27'd0, a, d});
  endtask

  task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    p_valid = pv; p_addr = pa; p_data = pd;
    m_valid = mv; m_addr = ma; m_data = md;
  endtask

  // Sample mid-cycle and score any write against the expected queue.
  task automatic sample();
    @(negedge clk);
    if (wen === 1'b1) begin
      n_chk++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write observed=%0h expected=none", {waddr, wdata});
      end
      if (sb.size() != 0) chk("write", {27'd0, waddr, wdata}, sb.pop_front());
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    // Reset behaviour
    sample();
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_pend", 64'(pend_mask), 64'd0);
    adv();
    sample(); adv();
    rst_n = 1'b1;
    sample();
    chk("post_rst_m_ready", 64'(m_ready), 64'd1);
    chk("post_rst_stall", 64'(stall_req), 64'd0);
    chk("post_rst_err", 64'(err), 64'd0);
    adv();

    // P-only write
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    expect_wr(5, 32'hDEADBEEF);
    sample();
    chk("p_only_m_ready", 64'(m_ready), 64'd1);
    adv();
    drive(0, 0, 0, 0, 0, 0);
    drain("p_only_drain");

    // Single m write, granted the cycle after acceptance
    drive(0, 0, 0, 1, 3, 32'h11);
    sample();
    chk("m_acc_ready", 64'(m_ready), 64'd1);
    chk("m_acc_pend", 64'(pend_mask), 64'd0);
    adv();
    drive(0, 0, 0, 0, 0, 0);
    expect_wr(3, 32'h11);
    sample();
    chk("m_pend_n1", 64'(pend_mask), 64'h8);
    adv();
    sample();
    chk("m_pend_n2", 64'(pend_mask), 64'd0);
    adv();
    drain("m_drain");

    // Simultaneous enqueue and dequeue on a 1-entry FIFO
    drive(0, 0, 0, 1, 14, 32'hE1);
    sample(); adv();
    drive(0, 0, 0, 1, 15, 32'hE2);
    expect_wr(14, 32'hE1);
    sample();
    chk("enqdeq_ready", 64'(m_ready), 64'd1);
    chk("enqdeq_pend_a", 64'(pend_mask), 64'h4000);
    adv();
    drive(0, 0, 0, 0, 0, 0);
    expect_wr(15, 32'hE2);
    sample();
    chk("enqdeq_pend_b", 64'(pend_mask), 64'h8000);
    adv();
    drain("enqdeq_drain");

    // Two m writes with P held: full, starvation, forced head
    drive(1, 20, 32'h100, 1, 12, 32'hA1);
    expect_wr(20, 32'h100);
    sample(); adv();
    drive(1, 21, 32'h101, 1, 13, 32'hA2);
    expect_wr(21, 32'h101);
    sample();
    chk("starve_ready_b", 64'(m_ready), 64'd1);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(22 + i), 32'(32'h102 + i), 0, 0, 0);
      expect_wr(5'(22 + i), 32'(32'h102 + i));
      sample();
      chk("starve_full_ready", 64'(m_ready), 64'd0);
      chk("starve_no_stall", 64'(stall_req), 64'd0);
      chk("starve_pend", 64'(pend_mask), 64'h3000);
      adv();
    end
    drive(0, 0, 0, 0, 0, 0);
    expect_wr(12, 32'hA1);
    sample();
    chk("starve_stall", 64'(stall_req), 64'd1);
    chk("starve_no_bypass", 64'(m_ready), 64'd0);
    adv();
    expect_wr(13, 32'hA2);
    sample();
    chk("starve_stall_clr", 64'(stall_req), 64'd0);
    chk("starve_ready_g", 64'(m_ready), 64'd1);
    adv();
    sample();
    chk("starve_err", 64'(err), 64'd0);
    adv();
    drain("starve_drain");

    // Stall while P keeps requesting: P write to x7 dropped, err sticky
    drive(0, 0, 0, 1, 9, 32'hB1);
    sample(); adv();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'(i), 0, 0, 0);
      expect_wr(1, 32'(i));
      sample(); adv();
    end
    drive(1, 7, 32'h77, 0, 0, 0);
    expect_wr(9, 32'hB1);
    sample();
    chk("viol_stall", 64'(stall_req), 64'd1);
    chk("viol_err_before", 64'(err), 64'd0);
    adv();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("viol_err_sticky", 64'(err), 64'd1);
      adv();
    end
    drain("viol_drain");

    // Writes to x0 from each source
    drive(1, 0, 32'h5A, 0, 0, 0);
    sample();
    chk("x0_p_wen", 64'(wen), 64'd0);
    adv();
    drive(0, 0, 0, 1, 0, 32'h55);
    sample(); adv();
    drive(0, 0, 0, 0, 0, 0);
    sample();
    chk("x0_m_wen", 64'(wen), 64'd0);
    chk("x0_m_pend", 64'(pend_mask), 64'd0);
    adv();
    drive(0, 0, 0, 1, 6, 32'h66);
    sample(); adv();
    drive(0, 0, 0, 0, 0, 0);
    expect_wr(6, 32'h66);
    sample();
    chk("x0_popped_pend", 64'(pend_mask), 64'h40);
    adv();
    drain("x0_drain");

    // Reset with two entries queued
    drive(1, 2, 32'hC0, 1, 11, 32'hD1);
    expect_wr(2, 32'hC0);
    sample(); adv();
    drive(1, 2, 32'hC1, 1, 12, 32'hD2);
    expect_wr(2, 32'hC1);
    sample(); adv();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    sample();
    chk("mid_rst_wen", 64'(wen), 64'd0);
    chk("mid_rst_pend", 64'(pend_mask), 64'd0);
    chk("mid_rst_ready", 64'(m_ready), 64'd0);
    chk("mid_rst_err_held", 64'(err), 64'd1);
    adv();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("post_mid_rst_pend", 64'(pend_mask), 64'd0);
      chk("post_mid_rst_stall", 64'(stall_req), 64'd0);
      chk("post_mid_rst_err", 64'(err), 64'd0);
      chk("post_mid_rst_wen", 64'(wen), 64'd0);
      adv();
    end
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
